// File: rtl/data_mem_lsu_pkg.sv
// rtl/data_mem_lsu_pkg.sv - shared encodings for the data memory load/store unit
package dm_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [1:0] MD_NORMAL = 2'd0;
    localparam logic [1:0] MD_LEFT   = 2'd1;
    localparam logic [1:0] MD_RIGHT  = 2'd2;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

endpackage

// File: rtl/data_mem_lsu_if.sv
// rtl/data_mem_lsu_if.sv - request/response bundle between the MEM stage and the data memory
interface data_mem_lsu_if #(
    parameter int ADDR_WIDTH = 13
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic [1:0]            req_mode;
    logic                  req_signed;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  rsp_valid;
    logic [31:0]           rsp_rdata;
    logic                  rsp_fault;
    logic                  clearing;

    modport master (
        output req_valid, req_write, req_size, req_mode, req_signed, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault, clearing
    );

    modport slave (
        input  req_valid, req_write, req_size, req_mode, req_signed, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault, clearing
    );
endinterface

// File: rtl/dm_lane_align.sv
// rtl/dm_lane_align.sv - byte-lane enables, store data shifting, fault decode and load extract/merge
module dm_lane_align
    import dm_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  mode,
    input  logic        sign,
    input  logic [1:0]  k,
    input  logic [31:0] wdata,
    input  logic [31:0] word,
    output logic [3:0]  be,
    output logic [31:0] wshift,
    output logic        fault,
    output logic [31:0] rdata
);
    logic [5:0] sh_k;
    logic [5:0] sh_l;
    logic [5:0] sh_kp1;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign sh_k   = {k, 3'b000};
    assign sh_l   = {~k, 3'b000};
    assign sh_kp1 = {({1'b0, k} + 3'd1), 3'b000};
    assign lane_b = word[{k, 3'b000} +: 8];
    // Odd half offsets fault, so only k[1] selects the half.
    assign lane_h = word[{k[1], 4'b0000} +: 16];

    assign fault = (size == 2'd3) || (mode == 2'd3)
                || (size == SZ_HALF && k[0])
                || (size == SZ_WORD && mode == MD_NORMAL && k != 2'd0)
                || (mode != MD_NORMAL && size != SZ_WORD);

    always_comb begin
        be     = 4'b0000;
        wshift = wdata;
        rdata  = '0;
        if (!fault) begin
            case (mode)
                MD_LEFT: begin
                    be     = 4'hF >> ~k;
                    wshift = wdata >> sh_l;
                    rdata  = (word << sh_l) | (wdata & (32'hFFFF_FFFF >> sh_kp1));
                end
                MD_RIGHT: begin
                    be     = 4'hF << k;
                    wshift = wdata << sh_k;
                    rdata  = (word >> sh_k) | (wdata & ~(32'hFFFF_FFFF >> sh_k));
                end
                default: begin
                    case (size)
                        SZ_BYTE: begin
                            be     = 4'b0001 << k;
                            wshift = {4{wdata[7:0]}};
                            rdata  = {{24{sign & lane_b[7]}}, lane_b};
                        end
                        SZ_HALF: begin
                            be     = 4'b0011 << k;
                            wshift = {2{wdata[15:0]}};
                            rdata  = {{16{sign & lane_h[15]}}, lane_h};
                        end
                        default: begin
                            be     = 4'hF;
                            wshift = wdata;
                            rdata  = word;
                        end
                    endcase
                end
            endcase
        end
    end
endmodule

// File: rtl/data_mem_lsu.sv
// rtl/data_mem_lsu.sv - data memory with clear sequencer, lane alignment and registered response
module data_mem_lsu
    import dm_pkg::*;
#(
    parameter int ADDR_WIDTH = 13
) (
    input  logic          clk,
    input  logic          reset,
    data_mem_lsu_if.slave bus
);
    localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);

    logic [31:0]           mem [DEPTH];
    state_e                state;
    logic [ADDR_WIDTH-3:0] clr_idx;
    logic [ADDR_WIDTH-3:0] w;
    logic [1:0]            k;
    logic                  accept;
    logic [3:0]            be;
    logic [31:0]           wshift;
    logic                  fault;
    logic [31:0]           ld_data;
    logic                  rsp_valid_q;
    logic                  rsp_fault_q;
    logic [31:0]           rsp_rdata_q;

    assign w      = bus.req_addr[ADDR_WIDTH-1:2];
    assign k      = bus.req_addr[1:0];
    assign accept = bus.req_valid && bus.req_ready;

    dm_lane_align u_align (
        .size   (bus.req_size),
        .mode   (bus.req_mode),
        .sign   (bus.req_signed),
        .k      (k),
        .wdata  (bus.req_wdata),
        .word   (mem[w]),
        .be     (be),
        .wshift (wshift),
        .fault  (fault),
        .rdata  (ld_data)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == CLEAR) begin
                mem[clr_idx] <= '0;
            end else if (accept && bus.req_write && !fault) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) mem[w][8*i +: 8] <= wshift[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= CLEAR;
            clr_idx     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_fault_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            if (state == CLEAR) begin
                clr_idx <= clr_idx + 1'b1;
                if (&clr_idx) state <= READY;
            end
            rsp_valid_q <= accept;
            rsp_fault_q <= accept && fault;
            rsp_rdata_q <= (accept && !bus.req_write) ? ld_data : 32'd0;
        end
    end

    // Reset masks the outputs so a response pending when reset rises never shows.
    assign bus.req_ready = (state == READY) && !reset;
    assign bus.clearing  = (state == CLEAR) || reset;
    assign bus.rsp_valid = rsp_valid_q && !reset;
    assign bus.rsp_fault = rsp_fault_q && !reset;
    assign bus.rsp_rdata = reset ? 32'd0 : rsp_rdata_q;
endmodule

// File: tb/tb_data_mem_lsu.sv
// tb/tb_data_mem_lsu.sv - self-checking bench for data_mem_lsu against a byte-array model
module tb_data_mem_lsu;
    localparam int AW = 6;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [31:0] last_rdata;
    logic [7:0]  mm [64];

    data_mem_lsu_if #(.ADDR_WIDTH(AW)) bus ();

    data_mem_lsu #(.ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) mm[i] = 8'h00;
    endtask

    task automatic model_req(input logic wr, input logic [1:0] sz, input logic [1:0] md,
                             input logic sg, input logic [5:0] ad, input logic [31:0] wd,
                             output logic ef, output logic [31:0] er);
        int k;
        int base;
        int sh;
        logic [31:0] word;
        logic [31:0] t;
        k    = int'(ad[1:0]);
        base = int'(ad) - k;
        word = {mm[base+3], mm[base+2], mm[base+1], mm[base]};
        ef = (sz == 2'd3) || (md == 2'd3) || (sz == 2'd1 && ad[0])
          || (sz == 2'd2 && md == 2'd0 && k != 0) || (md != 2'd0 && sz != 2'd2);
        er = 32'd0;
        if (ef) return;
        if (wr) begin
            if (md == 2'd0) begin
                for (int i = 0; i < (1 << sz); i++) mm[int'(ad) + i] = wd[8*i +: 8];
            end else if (md == 2'd1) begin
                t = wd >> (8 * (3 - k));
                for (int i = 0; i <= k; i++) mm[base + i] = t[8*i +: 8];
            end else begin
                t = wd << (8 * k);
                for (int i = k; i < 4; i++) mm[base + i] = t[8*i +: 8];
            end
        end else if (md == 2'd0) begin
            case (sz)
                2'd0:    er = {{24{sg & mm[ad][7]}}, mm[ad]};
                2'd1:    er = {{16{sg & mm[ad+1][7]}}, mm[ad+1], mm[ad]};
                default: er = word;
            endcase
        end else if (md == 2'd1) begin
            sh = 8 * (3 - k);
            er = (word << sh) | (wd & 32'((64'd1 << sh) - 64'd1));
        end else begin
            er = (word >> (8 * k)) | (wd & ~(32'hFFFF_FFFF >> (8 * k)));
        end
    endtask

    task automatic issue(input logic wr, input logic [1:0] sz, input logic [1:0] md,
                         input logic sg, input logic [5:0] ad, input logic [31:0] wd,
                         input string tag);
        logic        ef;
        logic [31:0] er;
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_size   = sz;
        bus.req_mode   = md;
        bus.req_signed = sg;
        bus.req_addr   = ad;
        bus.req_wdata  = wd;
        chk({tag, ".ready"}, 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        model_req(wr, sz, md, sg, ad, wd, ef, er);
        chk({tag, ".valid"}, 32'(bus.rsp_valid), 32'd1);
        chk({tag, ".fault"}, 32'(bus.rsp_fault), 32'(ef));
        chk({tag, ".rdata"}, bus.rsp_rdata, er);
        last_rdata = bus.rsp_rdata;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!bus.req_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (!bus.req_ready) chk({tag, ".nvalid"}, 32'(bus.rsp_valid), 32'd0);
        end
        chk({tag, ".cycles"}, 32'(n), 32'd16);
    endtask

    initial begin
        logic [1:0] sz;
        logic [1:0] md;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_size   = 2'd0;
        bus.req_mode   = 2'd0;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("rst.clearing", 32'(bus.clearing), 32'd1);
        chk("rst.ready", 32'(bus.req_ready), 32'd0);
        chk("rst.valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst.rdata", bus.rsp_rdata, 32'd0);
        chk("rst.fault", 32'(bus.rsp_fault), 32'd0);
        reset = 1'b0;
        wait_ready("clear0");
        chk("ready.clearing", 32'(bus.clearing), 32'd0);

        issue(0, 2'd2, 2'd0, 0, 6'h3C, 32'h0, "lw3c");
        chk("lw3c.lit", last_rdata, 32'h0000_0000);

        issue(1, 2'd2, 2'd0, 0, 6'h10, 32'h1122_3344, "sw10");
        issue(1, 2'd0, 2'd0, 0, 6'h12, 32'h0000_00AA, "sb12");
        issue(0, 2'd2, 2'd0, 0, 6'h10, 32'h0, "lw10");
        chk("lw10.lit", last_rdata, 32'h11AA_3344);
        issue(0, 2'd0, 2'd0, 1, 6'h12, 32'h0, "lb12");
        chk("lb12.lit", last_rdata, 32'hFFFF_FFAA);
        issue(0, 2'd0, 2'd0, 0, 6'h12, 32'h0, "lbu12");
        chk("lbu12.lit", last_rdata, 32'h0000_00AA);
        issue(0, 2'd1, 2'd0, 1, 6'h12, 32'h0, "lh12");
        chk("lh12.lit", last_rdata, 32'h0000_11AA);

        issue(1, 2'd2, 2'd0, 0, 6'h20, 32'h4433_2211, "sw20");
        issue(0, 2'd2, 2'd1, 0, 6'h21, 32'hAABB_CCDD, "lwl21");
        chk("lwl21.lit", last_rdata, 32'h2211_CCDD);
        issue(0, 2'd2, 2'd2, 0, 6'h21, 32'hAABB_CCDD, "lwr21");
        chk("lwr21.lit", last_rdata, 32'hAA44_3322);
        issue(1, 2'd2, 2'd1, 0, 6'h21, 32'hAABB_CCDD, "swl21");
        issue(0, 2'd2, 2'd0, 0, 6'h20, 32'h0, "lw20a");
        chk("swl21.lit", last_rdata, 32'h4433_AABB);
        issue(1, 2'd2, 2'd0, 0, 6'h20, 32'h4433_2211, "sw20b");
        issue(1, 2'd2, 2'd2, 0, 6'h22, 32'hAABB_CCDD, "swr22");
        issue(0, 2'd2, 2'd0, 0, 6'h20, 32'h0, "lw20b");
        chk("swr22.lit", last_rdata, 32'hCCDD_2211);

        issue(0, 2'd1, 2'd0, 1, 6'h01, 32'h0, "flh01");
        chk("flh01.lit", 32'(bus.rsp_fault), 32'd1);
        issue(0, 2'd2, 2'd0, 0, 6'h02, 32'h0, "flw02");
        chk("flw02.lit", 32'(bus.rsp_fault), 32'd1);
        issue(0, 2'd3, 2'd0, 0, 6'h20, 32'h0, "fsz3");
        issue(0, 2'd0, 2'd1, 0, 6'h20, 32'hFFFF_FFFF, "flwl0");
        issue(1, 2'd0, 2'd1, 0, 6'h20, 32'h1234_5678, "fswl0");
        issue(1, 2'd2, 2'd0, 0, 6'h22, 32'h0, "fsw22");
        issue(0, 2'd2, 2'd0, 0, 6'h20, 32'h0, "lw20c");
        chk("fault.unchanged", last_rdata, 32'hCCDD_2211);

        issue(1, 2'd2, 2'd0, 0, 6'h08, 32'hDEAD_BEEF, "b2b.sw");
        issue(0, 2'd2, 2'd0, 0, 6'h08, 32'h0, "b2b.lw");
        chk("b2b.lit", last_rdata, 32'hDEAD_BEEF);

        for (int i = 0; i < 300; i++) begin
            md = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) sz = 2'($urandom_range(0, 3));
            else if (md != 2'd0) sz = 2'd2;
            else sz = 2'($urandom_range(0, 2));
            issue(1'($urandom_range(0, 1)), sz, md, 1'($urandom_range(0, 1)),
                  6'($urandom_range(0, 63)), $urandom, "rnd");
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
                chk("idle.valid", 32'(bus.rsp_valid), 32'd0);
            end
        end
        for (int i = 0; i < 16; i++) issue(0, 2'd2, 2'd0, 0, 6'(4 * i), 32'h0, "sweep");

        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        repeat (5) @(posedge clk);
        #1;
        chk("mid.clearing", 32'(bus.clearing), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        wait_ready("clear1");

        issue(1, 2'd2, 2'd0, 0, 6'h3C, 32'h5555_AAAA, "sw3c");
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 6'h3C;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("rstld.valid", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        chk("rstld.after", 32'(bus.rsp_valid), 32'd0);
        wait_ready("clear2");
        issue(0, 2'd2, 2'd0, 0, 6'h3C, 32'h0, "lw3c.post");
        chk("lw3c.post.lit", last_rdata, 32'h0000_0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/data_mem_lsu.md
# data_mem_lsu

- Parametrised data memory with an integrated load/store alignment unit for the pipelined CPU's MEM stage.
- Supports byte/half/word loads and stores with sign or zero extension, plus unaligned left/right word accesses (LWL/LWR/SWL/SWR), misalignment faults, and a registered one-cycle read.
- Instead of a one-cycle bulk reset, a hardware clear sequencer zeroes the array one word per cycle and holds off requests until it finishes.

## Interface
Parameters:
- ADDR_WIDTH, 13: byte-address width. Memory size is 2^ADDR_WIDTH bytes.
- DEPTH, 2^(ADDR_WIDTH-2): word count, derived, not overridable.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept; low while clearing.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
- req_mode  in  2  0 = normal, 1 = left (LWL/SWL), 2 = right (LWR/SWR); 3 is illegal.
- req_signed  in  1  sign-extend byte/half loads.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data; rt old value for LWL/LWR merge.
- rsp_valid  out  1  one-cycle pulse, one per accepted request.
- rsp_rdata  out  32  load result; 0 for stores and faults.
- rsp_fault  out  1  alignment or encoding fault, valid with rsp_valid.
- clearing  out  1  clear sequencer active.

## Operation
- States:
  - CLEAR: clr_idx counts 0..DEPTH-1 and writes mem[clr_idx] = 0 each cycle. After DEPTH-1 it moves to READY.
  - READY: req_ready = 1.
- Accept occurs when req_valid && req_ready.
- Let w = req_addr[ADDR_WIDTH-1:2] and k = req_addr[1:0].
- Fault conditions: size = 3 or mode = 3; half with k[0] = 1; word normal with k != 0; mode != 0 with size != 2.
- On a fault: no array write, rsp_fault = 1, rsp_rdata = 0.
- Normal stores write the byte lanes selected by k and size: byte writes lane k from wdata[7:0]; half writes lanes k..k+1 from wdata[15:0]; word writes all lanes.
- SWL writes bytes 0..k of mem[w] with wdata >> 8*(3-k).
- SWR writes bytes k..3 of mem[w] with wdata << 8*k.
- Normal loads extract lane(s) at k, then zero- or sign-extend per req_signed. Word loads ignore req_signed.
- LWL: rdata = (word << 8*(3-k)) | (wdata & ((1 << 8*(3-k)) - 1)).
- LWR: rdata = (word >> 8*k) | (wdata & ~(32'hFFFFFFFF >> 8*k)).
- Little-endian byte numbering throughout: lane 0 = bits [7:0].

## Timing
- Reset values: state = CLEAR, clr_idx = 0, clearing = 1, req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_fault = 0.
- Clear duration: reset deasserts at edge 0. Words 0..DEPTH-1 are cleared on edges 1..DEPTH. req_ready = 1 in the cycle after edge DEPTH.
- Reset asserted mid-clear or mid-request restarts CLEAR at index 0. Any pending rsp_valid is dropped, and the response for a request accepted on the reset edge is discarded.
- Stores update the array on the accepting edge.
- Load data is captured on the accepting edge. rsp_valid/rsp_rdata/rsp_fault are visible for exactly one cycle after acceptance (latency 1).
- Throughput is one request per cycle with no backpressure on the response side.
- A load accepted in the cycle after a store to the same word returns the post-store value.
- A store and a load cannot be accepted in the same cycle: single request port.

## Structure
- Package dm_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - mode encodings MD_NORMAL/MD_LEFT/MD_RIGHT;
  - the state enum CLEAR/READY.
- One combinational sub-module, dm_lane_align, computes byte-enable mask, shifted write data, fault, and load extract/merge from (size, mode, signed, k, wdata, word).
- The top level holds the array, clear sequencer, and response registers.

## Test plan
- Clear: with ADDR_WIDTH = 6, deassert reset and count cycles → req_ready rises after exactly 16 cycles. A load of 0x3C then returns 0x00000000.
- Byte/half lanes: SW 0x11223344 @0x10, then SB 0xAA @0x12 → LW @0x10 = 0x11AA3344; LB @0x12 = 0xFFFFFFAA; LBU @0x12 = 0x000000AA; LH @0x12 = 0x000011AA.
- Unaligned: mem[0x20] = 0x44332211, rt = 0xAABBCCDD:
  - LWL @0x21 → 0x2211CCDD; LWR @0x21 → 0xAA443322.
  - SWL @0x21 → mem 0x4433AABB; SWR @0x22 (on the original word) → 0xCCDD2211.
- Faults: LH @0x01, LW @0x02, size = 3, LWL with size = 0 → each gives rsp_fault = 1 and rsp_rdata = 0, with the memory unchanged.
- Back-to-back: accept SW 0xDEADBEEF @0x08, then LW @0x08 on consecutive cycles → the second response returns 0xDEADBEEF one cycle after its acceptance.
- Reset mid-operation: assert reset during clear index 5 and again the cycle after a load accepts → no rsp_valid pulse; clearing restarts from index 0.
